// File: rtl/ether_tx_seq.sv
// Ethernet TX frame sequencer for the RMII dibit path: preamble/SFD, payload,
// zero pad to minimum length, FCS, then inter-frame gap. Includes its CRC32 engine.

module fcs_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        axiiv,
    input  logic [1:0]  axiid,
    output logic        axiov,
    output logic [31:0] cksum
);
    logic [31:0] crc;
    logic        seen;

    // Reflected CRC32 (poly 0xEDB88320), axiid[0] is the earlier bit on the wire.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        return (c >> 1) ^ (fb ? 32'hEDB88320 : 32'h0000_0000);
    endfunction

    // rst here is active-high: the sequencer holds it during IDLE/PREAMBLE/IFG.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc  <= 32'hFFFF_FFFF;
            seen <= 1'b0;
        end else if (axiiv) begin
            crc  <= crc_step(crc_step(crc, axiid[0]), axiid[1]);
            seen <= 1'b1;
        end
    end

    assign axiov = seen;
    assign cksum = ~crc;
endmodule

module ether_tx_seq #(
    parameter int PREAMBLE_DIBITS = 31,
    parameter int MIN_DIBITS      = 240,
    parameter int IFG_DIBITS      = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [1:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       busy,
    output logic       frame_done,
    output logic       err
);
    localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_DIBITS);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_DIBITS - 1);
    localparam logic [7:0]  FCS_LAST = 8'd15;
    localparam logic [15:0] MIN_CNT  = 16'(MIN_DIBITS);

    typedef enum logic [2:0] {IDLE, PREAMBLE, PAYLOAD, PAD, FCS, IFG} state_t;

    state_t      state, state_next;
    logic [7:0]  phase_cnt, phase_next;
    logic [15:0] dibit_cnt, dibit_next, dibit_inc;
    logic [31:0] shreg, shreg_next;
    logic        axiov_next, frame_done_next, err_next;
    logic [1:0]  axiod_next;
    logic        fcs_rst, fcs_feed, fcs_valid;
    logic [1:0]  fcs_data;
    logic [31:0] fcs_sum;

    assign fcs_rst   = !rst || (state == IDLE) || (state == PREAMBLE) || (state == IFG);
    assign in_ready  = (state == PAYLOAD);
    assign dibit_inc = (dibit_cnt == 16'hFFFF) ? dibit_cnt : dibit_cnt + 16'd1;

    fcs_gen u_fcs (
        .clk   (clk),
        .rst   (fcs_rst),
        .axiiv (fcs_feed),
        .axiid (fcs_data),
        .axiov (fcs_valid),
        .cksum (fcs_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            dibit_cnt  <= '0;
            shreg      <= '0;
            axiov      <= 1'b0;
            axiod      <= 2'b00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_next;
            phase_cnt  <= phase_next;
            dibit_cnt  <= dibit_next;
            shreg      <= shreg_next;
            axiov      <= axiov_next;
            axiod      <= axiod_next;
            busy       <= (state_next != IDLE);
            frame_done <= frame_done_next;
            err        <= err_next;
        end
    end

    // Each state computes what the wire shows on the following cycle.
    always_comb begin
        state_next      = state;
        phase_next      = phase_cnt;
        dibit_next      = dibit_cnt;
        shreg_next      = shreg;
        axiov_next      = 1'b0;
        axiod_next      = 2'b00;
        frame_done_next = 1'b0;
        err_next        = 1'b0;
        fcs_feed        = 1'b0;
        fcs_data        = 2'b00;

        case (state)
            IDLE: begin
                phase_next = '0;
                dibit_next = '0;
                if (in_valid) state_next = PREAMBLE;
            end
            PREAMBLE: begin
                axiov_next = 1'b1;
                if (phase_cnt == PRE_LAST) begin
                    axiod_next = 2'b11;
                    phase_next = '0;
                    state_next = PAYLOAD;
                end else begin
                    axiod_next = 2'b01;
                    phase_next = phase_cnt + 8'd1;
                end
            end
            PAYLOAD: begin
                if (in_valid) begin
                    axiov_next = 1'b1;
                    axiod_next = in_data;
                    fcs_feed   = 1'b1;
                    fcs_data   = in_data;
                    dibit_next = dibit_inc;
                    if (in_last) state_next = (dibit_inc < MIN_CNT) ? PAD : FCS;
                end else begin
                    err_next   = 1'b1;
                    phase_next = '0;
                    state_next = IFG;
                end
            end
            PAD: begin
                axiov_next = 1'b1;
                fcs_feed   = 1'b1;
                dibit_next = dibit_inc;
                if (dibit_inc >= MIN_CNT) state_next = FCS;
            end
            FCS: begin
                if (phase_cnt == 8'd0 && !fcs_valid) begin
                    err_next   = 1'b1;
                    phase_next = '0;
                    state_next = IFG;
                end else begin
                    axiov_next = 1'b1;
                    if (phase_cnt == 8'd0) begin
                        axiod_next = fcs_sum[1:0];
                        shreg_next = {2'b00, fcs_sum[31:2]};
                    end else begin
                        axiod_next = shreg[1:0];
                        shreg_next = {2'b00, shreg[31:2]};
                    end
                    if (phase_cnt == FCS_LAST) begin
                        frame_done_next = 1'b1;
                        phase_next      = '0;
                        state_next      = IFG;
                    end else begin
                        phase_next = phase_cnt + 8'd1;
                    end
                end
            end
            IFG: begin
                dibit_next = '0;
                if (phase_cnt == IFG_LAST) begin
                    phase_next = '0;
                    state_next = in_valid ? PREAMBLE : IDLE;
                end else begin
                    phase_next = phase_cnt + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ether_tx_seq.sv
// Self-checking bench for ether_tx_seq: table-driven frames with a wire
// scoreboard, plus hand-written underrun, reset and back-to-back sequences.

module tb_ether_tx_seq;
    localparam int PAT_RANDOM = 0;
    localparam int PAT_MSG    = 1;
    localparam int PAT_ONES   = 2;
    localparam int MIN_D      = 240;

    typedef logic [1:0] dibit_q_t[$];
    typedef struct {
        logic [1:0] dibit;
        bit         last;
        int         len;
    } exp_t;
    typedef struct {
        int len;
        int pattern;
        int exp_len;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_data = 2'b00;
    logic       in_last = 1'b0;
    logic       in_ready, axiov, busy, frame_done, err;
    logic [1:0] axiod;

    int   check_count = 0;
    int   error_count = 0;
    exp_t sb_q[$];
    bit   mon_en = 1'b0;
    bit   gap_armed = 1'b0;
    bit   prev_axiov = 1'b0;
    int   run_len = 0;
    int   cyc = 0;
    int   done_cyc = 0;
    vec_t vecs[7];

    ether_tx_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .axiov      (axiov),
        .axiod      (axiod),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input int actual, input int expected);
        check_count++;
        if (actual != expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // Byte-oriented software CRC32; dibit i of a byte holds bits [2i+1:2i].
    function automatic logic [31:0] crc32_dibits(input dibit_q_t d);
        logic [31:0] crc;
        logic [7:0]  b;
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i + 3 < d.size(); i += 4) begin
            b = {d[i+3], d[i+2], d[i+1], d[i]};
            crc = crc ^ {24'h0, b};
            for (int k = 0; k < 8; k++)
                crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
        end
        return ~crc;
    endfunction

    task automatic make_payload(input int len, input int pattern, output dibit_q_t pl);
        logic [167:0] msg;
        logic [7:0]   b;
        msg = 168'h4261_7272_7921_2042_7265_616b_6661_7374_2074_696d65;
        pl.delete();
        if (pattern == PAT_MSG) begin
            for (int j = 20; j >= 0; j--) begin
                b = msg[8*j +: 8];
                pl.push_back(b[1:0]);
                pl.push_back(b[3:2]);
                pl.push_back(b[5:4]);
                pl.push_back(b[7:6]);
            end
        end else begin
            for (int j = 0; j < len; j++)
                pl.push_back(pattern == PAT_ONES ? 2'b11 : 2'($urandom_range(0, 3)));
        end
    endtask

    // Pushes the expected wire image, then plays the payload as an upstream source.
    task automatic apply_stimulus(input dibit_q_t pl, input int drop_at, input bit hold_after,
                                  input int exp_len);
        dibit_q_t    body;
        logic [31:0] fcs;
        int          n, idx, budget;
        exp_t        e;
        n = pl.size();
        e.last = 1'b0;
        e.len  = 0;
        for (int j = 0; j < 31; j++) begin e.dibit = 2'b01; sb_q.push_back(e); end
        e.dibit = 2'b11; sb_q.push_back(e);
        if (drop_at >= 0) begin
            for (int j = 0; j < drop_at; j++) begin e.dibit = pl[j]; sb_q.push_back(e); end
        end else begin
            body = pl;
            while (body.size() < MIN_D) body.push_back(2'b00);
            fcs = crc32_dibits(body);
            foreach (body[j]) begin e.dibit = body[j]; sb_q.push_back(e); end
            for (int k = 0; k < 16; k++) begin
                e.dibit = fcs[2*k +: 2];
                e.last  = (k == 15);
                e.len   = exp_len;
                sb_q.push_back(e);
            end
        end
        idx = 0;
        budget = 0;
        in_valid = 1'b1;
        in_data  = pl[0];
        in_last  = (n == 1);
        while (idx < n) begin
            @(negedge clk);
            budget++;
            if (budget > 4000) begin
                check_output("send timeout", idx, n);
                break;
            end
            if (in_ready && in_valid) begin
                @(posedge clk);
                #1;
                idx++;
                if (idx == drop_at) begin
                    in_valid = 1'b0; in_data = 2'b00; in_last = 1'b0;
                    break;
                end
                if (idx < n) begin
                    in_data = pl[idx];
                    in_last = (idx == n - 1);
                end else begin
                    in_valid = hold_after; in_data = 2'b00; in_last = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int budget;
        budget = 0;
        @(negedge clk);
        while ((busy || sb_q.size() != 0) && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 3000) check_output(name, sb_q.size() + 32'(busy), 0);
    endtask

    // Wire monitor: pops the scoreboard on every axiov cycle.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (axiov) begin
                run_len++;
                if (sb_q.size() == 0) begin
                    check_output("unexpected axiov", 32'(axiov), 0);
                end else begin
                    e = sb_q.pop_front();
                    check_output("axiod", 32'(axiod), 32'(e.dibit));
                    check_output("frame_done", 32'(frame_done), 32'(e.last));
                    if (e.last) check_output("axiov length", run_len, e.len);
                end
                if (!prev_axiov && gap_armed) begin
                    check_output("ifg gap", cyc - done_cyc, 49);
                    gap_armed = 1'b0;
                end
            end else begin
                run_len = 0;
                check_output("axiod idle", 32'(axiod), 0);
                check_output("frame_done idle", 32'(frame_done), 0);
            end
            if (frame_done) done_cyc = cyc;
        end
        prev_axiov = axiov;
    end

    initial begin
        dibit_q_t pl, pl2;
        int       e0, budget;

        vecs[0] = '{len: 240, pattern: PAT_RANDOM, exp_len: 288};
        vecs[1] = '{len: 56,  pattern: PAT_RANDOM, exp_len: 288};
        vecs[2] = '{len: 84,  pattern: PAT_MSG,    exp_len: 288};
        vecs[3] = '{len: 1,   pattern: PAT_RANDOM, exp_len: 288};
        vecs[4] = '{len: 239, pattern: PAT_RANDOM, exp_len: 288};
        vecs[5] = '{len: 244, pattern: PAT_RANDOM, exp_len: 292};
        vecs[6] = '{len: 100, pattern: PAT_ONES,   exp_len: 288};

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_output("reset axiov", 32'(axiov), 0);
        check_output("reset in_ready", 32'(in_ready), 0);
        check_output("reset busy", 32'(busy), 0);
        check_output("reset err", 32'(err), 0);
        mon_en = 1'b1;

        foreach (vecs[i]) begin
            make_payload(vecs[i].len, vecs[i].pattern, pl);
            apply_stimulus(pl, -1, 1'b0, vecs[i].exp_len);
            wait_idle("frame drain timeout");
            check_output("ifg length", cyc - done_cyc, 48);
        end

        // Underrun at payload dibit 100, then a clean frame.
        make_payload(240, PAT_RANDOM, pl);
        apply_stimulus(pl, 100, 1'b0, 0);
        @(posedge clk);
        @(negedge clk);
        e0 = cyc;
        check_output("underrun err", 32'(err), 1);
        check_output("underrun axiov", 32'(axiov), 0);
        check_output("underrun busy", 32'(busy), 1);
        @(negedge clk);
        check_output("err one cycle", 32'(err), 0);
        budget = 0;
        while (busy && budget < 200) begin @(negedge clk); budget++; end
        check_output("underrun ifg", cyc - e0, 48);
        check_output("underrun leftovers", sb_q.size(), 0);
        make_payload(64, PAT_RANDOM, pl);
        apply_stimulus(pl, -1, 1'b0, 288);
        wait_idle("post-underrun timeout");

        // Reset pulse in the middle of a payload.
        mon_en = 1'b0;
        in_valid = 1'b1; in_data = 2'b10; in_last = 1'b0;
        budget = 0;
        do begin @(negedge clk); budget++; end while (!in_ready && budget < 200);
        check_output("reset test reached payload", 32'(in_ready), 1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1; in_valid = 1'b0; in_data = 2'b00;
        @(negedge clk);
        check_output("midframe reset axiov", 32'(axiov), 0);
        check_output("midframe reset axiod", 32'(axiod), 0);
        check_output("midframe reset in_ready", 32'(in_ready), 0);
        check_output("midframe reset busy", 32'(busy), 0);
        check_output("midframe reset err", 32'(err), 0);
        sb_q.delete();
        @(negedge clk);
        mon_en = 1'b1;
        make_payload(240, PAT_RANDOM, pl);
        apply_stimulus(pl, -1, 1'b0, 288);
        wait_idle("post-reset timeout");

        // Back-to-back frames with in_valid held through the gap.
        make_payload(120, PAT_RANDOM, pl);
        make_payload(240, PAT_RANDOM, pl2);
        apply_stimulus(pl, -1, 1'b1, 288);
        gap_armed = 1'b1;
        apply_stimulus(pl2, -1, 1'b0, 288);
        wait_idle("back-to-back timeout");
        if (gap_armed) check_output("second frame start seen", 0, 1);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end
endmodule
